// File: rtl/xtea_pkg.sv
// Shared types and widths for the XTEA engine arbiter.
package xtea_pkg;

  localparam int XTEA_W   = 128;
  localparam int TO_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_READY,
    ST_WAIT_IDLE,
    ST_RESPOND
  } state_t;

endpackage

// File: rtl/xtea_arbiter_if.sv
// Requester, response and engine signals of the arbiter.
// slave = arbiter side, master = requesters plus engine.
interface xtea_arbiter_if;

  logic                        req0_valid, req1_valid;
  logic                        req0_ready, req1_ready;
  logic                        req0_cfg, req1_cfg;
  logic [xtea_pkg::XTEA_W-1:0] req0_data, req1_data;
  logic [xtea_pkg::XTEA_W-1:0] req0_key, req1_key;
  logic                        rsp0_valid, rsp1_valid;
  logic                        rsp0_ready, rsp1_ready;
  logic [xtea_pkg::XTEA_W-1:0] rsp_data;
  logic                        rsp_err;
  logic                        eng_start, eng_cfg;
  logic [xtea_pkg::XTEA_W-1:0] eng_data, eng_key, eng_data_o;
  logic                        eng_ready, eng_busy;

  modport slave (
    input  req0_valid, req1_valid, req0_cfg, req1_cfg,
    input  req0_data, req1_data, req0_key, req1_key,
    input  rsp0_ready, rsp1_ready,
    input  eng_ready, eng_busy, eng_data_o,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output eng_start, eng_cfg, eng_data, eng_key
  );

  modport master (
    output req0_valid, req1_valid, req0_cfg, req1_cfg,
    output req0_data, req1_data, req0_key, req1_key,
    output rsp0_ready, rsp1_ready,
    output eng_ready, eng_busy, eng_data_o,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input  eng_start, eng_cfg, eng_data, eng_key
  );

endinterface

// File: rtl/xtea_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not granted last.
module xtea_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = valid[gi] && (!valid[1-gi] || (last_grant != 1'(gi)));
  end

endmodule

// File: rtl/xtea_arbiter.sv
// Shares one xtea_top engine between two requesters, sequences the engine
// handshake and returns the result (or a timeout error) to the owner.
module xtea_arbiter
  import xtea_pkg::*;
#(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clock,
  input logic           reset,
  xtea_arbiter_if.slave bus
);

  localparam logic [TO_CNT_W-1:0] START_LAST = TO_CNT_W'(START_CYCLES - 1);
  localparam logic [TO_CNT_W-1:0] TO_LAST    = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_reg;
  logic                  owner_reg;
  logic                  last_grant_reg;
  logic [TO_CNT_W-1:0]   start_cnt_reg;
  logic [TO_CNT_W-1:0]   to_cnt_reg;
  logic                  eng_start_reg;
  logic                  eng_cfg_reg;
  logic [XTEA_W-1:0]     eng_data_reg;
  logic [XTEA_W-1:0]     eng_key_reg;
  logic [XTEA_W-1:0]     rsp_data_reg;
  logic                  rsp_err_reg;
  logic                  rsp0_valid_reg;
  logic                  rsp1_valid_reg;

  logic [1:0] grant;
  logic       sel;
  logic       idle;
  logic       waiting;
  logic       done;
  logic       expire;
  logic       rsp_fire;

  xtea_rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign sel     = grant[1];
  assign idle    = (state_reg == ST_IDLE);
  assign waiting = (state_reg == ST_WAIT_READY) || (state_reg == ST_WAIT_IDLE);

  // Completion means the engine has gone idle; ready alone only delivers data.
  assign done = ((state_reg == ST_WAIT_READY) && bus.eng_ready && !bus.eng_busy) ||
                ((state_reg == ST_WAIT_IDLE) && !bus.eng_busy);
  assign expire   = waiting && !done && (to_cnt_reg >= TO_LAST);
  assign rsp_fire = (rsp0_valid_reg && bus.rsp0_ready) ||
                    (rsp1_valid_reg && bus.rsp1_ready);

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign bus.req0_ready = grant[0] && idle && reset;
  assign bus.req1_ready = grant[1] && idle && reset;
  assign bus.rsp0_valid = rsp0_valid_reg;
  assign bus.rsp1_valid = rsp1_valid_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign bus.rsp_err    = rsp_err_reg;
  assign bus.eng_start  = eng_start_reg;
  assign bus.eng_cfg    = eng_cfg_reg;
  assign bus.eng_data   = eng_data_reg;
  assign bus.eng_key    = eng_key_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      start_cnt_reg  <= '0;
      to_cnt_reg     <= '0;
      eng_start_reg  <= 1'b0;
      eng_cfg_reg    <= 1'b0;
      eng_data_reg   <= '0;
      eng_key_reg    <= '0;
      rsp_data_reg   <= '0;
      rsp_err_reg    <= 1'b0;
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (|grant) begin
            eng_cfg_reg    <= sel ? bus.req1_cfg  : bus.req0_cfg;
            eng_data_reg   <= sel ? bus.req1_data : bus.req0_data;
            eng_key_reg    <= sel ? bus.req1_key  : bus.req0_key;
            owner_reg      <= sel;
            last_grant_reg <= sel;
            eng_start_reg  <= 1'b1;
            start_cnt_reg  <= '0;
            state_reg      <= ST_START;
          end
        end
        ST_START: begin
          if (start_cnt_reg == START_LAST) begin
            eng_start_reg <= 1'b0;
            to_cnt_reg    <= '0;
            state_reg     <= ST_WAIT_READY;
          end else begin
            start_cnt_reg <= start_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_READY, ST_WAIT_IDLE: begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
          if ((state_reg == ST_WAIT_READY) && bus.eng_ready) begin
            rsp_data_reg <= bus.eng_data_o;
          end
          if (done || expire) begin
            state_reg      <= ST_RESPOND;
            rsp0_valid_reg <= !owner_reg;
            rsp1_valid_reg <= owner_reg;
            if (!done) begin
              rsp_err_reg  <= 1'b1;
              rsp_data_reg <= '0;
            end
          end else if ((state_reg == ST_WAIT_READY) && bus.eng_ready) begin
            state_reg <= ST_WAIT_IDLE;
          end
        end
        ST_RESPOND: begin
          if (rsp_fire) begin
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            rsp_err_reg    <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xtea_arbiter.sv
// Directed bench for xtea_arbiter: two instances (default timeout and a
// 16-cycle timeout), each driven by a behavioural engine that returns ~data.
module tb_xtea_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cmp_cnt = 0;
  int err_cnt = 0;

  localparam logic [127:0] D_SPEC  = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] K_SPEC  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] R_SPEC  = 128'hFEDCBA9876543210_0123456789ABCDEF;
  localparam logic [127:0] D_A     = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] R_A     = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] D_B     = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F;
  localparam logic [127:0] R_B     = 128'hF0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0;
  localparam logic [127:0] D_C     = 128'h00000000000000000000000000000001;
  localparam logic [127:0] R_C     = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE;

  // requester-side drive, routed to the instance selected by use_t
  logic         use_t = 1'b0;
  logic         v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0, r0 = 1'b0, r1 = 1'b0;
  logic [127:0] d0 = '0, d1 = '0, k0 = '0, k1 = '0;

  int m_lat[2]  = '{40, 5};
  int m_tail[2] = '{2, 1};
  bit m_hang[2] = '{1'b0, 1'b0};

  xtea_arbiter_if bus[2] ();

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    xtea_arbiter #(
      .START_CYCLES   (2),
      .TIMEOUT_CYCLES ((gi == 0) ? 1024 : 16)
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus[gi])
    );

    assign bus[gi].req0_valid = v0 && (use_t == (gi == 1));
    assign bus[gi].req1_valid = v1 && (use_t == (gi == 1));
    assign bus[gi].rsp0_ready = r0 && (use_t == (gi == 1));
    assign bus[gi].rsp1_ready = r1 && (use_t == (gi == 1));
    assign bus[gi].req0_cfg   = c0;
    assign bus[gi].req1_cfg   = c1;
    assign bus[gi].req0_data  = d0;
    assign bus[gi].req1_data  = d1;
    assign bus[gi].req0_key   = k0;
    assign bus[gi].req1_key   = k1;

    // engine model: starts on a rising eng_start, ready after m_lat cycles,
    // busy drops m_tail cycles after ready (0 = same edge)
    logic         start_d = 1'b0;
    logic         busy    = 1'b0;
    logic         ready   = 1'b0;
    logic [127:0] dout    = '0;
    int           cnt     = 0;

    always @(posedge clock) begin
      start_d <= bus[gi].eng_start;
      ready   <= 1'b0;
      if (bus[gi].eng_start && !start_d) begin
        busy <= 1'b1;
        cnt  <= 0;
        dout <= ~bus[gi].eng_data;
      end else if (busy) begin
        cnt <= cnt + 1;
        if (!m_hang[gi] && (cnt + 1 == m_lat[gi])) ready <= 1'b1;
        if (!m_hang[gi] && (cnt + 1 == m_lat[gi] + m_tail[gi])) busy <= 1'b0;
      end
    end

    assign bus[gi].eng_ready  = ready;
    assign bus[gi].eng_busy   = busy;
    assign bus[gi].eng_data_o = dout;
  end

  logic         s_r0, s_r1, s_v0, s_v1, s_err, s_start, s_cfg, s_eready, s_ebusy;
  logic [127:0] s_data, s_edata, s_ekey;
  assign s_r0     = use_t ? bus[1].req0_ready : bus[0].req0_ready;
  assign s_r1     = use_t ? bus[1].req1_ready : bus[0].req1_ready;
  assign s_v0     = use_t ? bus[1].rsp0_valid : bus[0].rsp0_valid;
  assign s_v1     = use_t ? bus[1].rsp1_valid : bus[0].rsp1_valid;
  assign s_err    = use_t ? bus[1].rsp_err    : bus[0].rsp_err;
  assign s_data   = use_t ? bus[1].rsp_data   : bus[0].rsp_data;
  assign s_start  = use_t ? bus[1].eng_start  : bus[0].eng_start;
  assign s_cfg    = use_t ? bus[1].eng_cfg    : bus[0].eng_cfg;
  assign s_edata  = use_t ? bus[1].eng_data   : bus[0].eng_data;
  assign s_ekey   = use_t ? bus[1].eng_key    : bus[0].eng_key;
  assign s_eready = use_t ? bus[1].eng_ready  : bus[0].eng_ready;
  assign s_ebusy  = use_t ? bus[1].eng_busy   : bus[0].eng_busy;

  // observations of one operation, in negedges after the acceptance point
  int           w_rsp, w_start_hi, w_ready, w_busy_fall, w_wr;
  bit           w_ok, w_any_rdy;
  logic         w_start1, w_cfg1;
  logic [127:0] w_edata1, w_ekey1;

  task automatic wait_rsp(input int budget, input logic [1:0] drop);
    bit saw_busy = 1'b0;
    w_ok = 1'b0; w_any_rdy = 1'b0; w_rsp = -1; w_start_hi = 0;
    w_ready = -1; w_busy_fall = -1; w_wr = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clock);
      if (n == 1) begin
        w_start1 = s_start; w_cfg1 = s_cfg; w_edata1 = s_edata; w_ekey1 = s_ekey;
        if (drop[0]) v0 = 1'b0;
        if (drop[1]) v1 = 1'b0;
      end
      if (s_r0 || s_r1) w_any_rdy = 1'b1;
      if (s_start) w_start_hi++;
      if (s_eready && w_ready < 0) w_ready = n;
      if (s_ebusy) saw_busy = 1'b1;
      else if (saw_busy && w_busy_fall < 0) w_busy_fall = n;
      if (!s_start && w_start_hi > 0 && w_wr < 0) w_wr = n;
      if (s_v0 || s_v1) begin
        w_ok = 1'b1; w_rsp = n;
        break;
      end
    end
  endtask

  task automatic handshake(input int ch);
    if (ch == 0) r0 = 1'b1; else r1 = 1'b1;
    @(negedge clock);
    r0 = 1'b0; r1 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    v0 = 1'b1;
    #2 reset = 1'b0;
    @(negedge clock);
    cmp_cnt++; if (s_r0 !== 1'b0) begin err_cnt++; $display("FAIL reset_req0_ready: got %b want 0", s_r0); end
    cmp_cnt++; if (s_start !== 1'b0) begin err_cnt++; $display("FAIL reset_eng_start: got %b want 0", s_start); end
    cmp_cnt++; if (s_edata !== '0) begin err_cnt++; $display("FAIL reset_eng_data: got %h want 0", s_edata); end
    cmp_cnt++; if (s_data !== '0) begin err_cnt++; $display("FAIL reset_rsp_data: got %h want 0", s_data); end
    cmp_cnt++; if ({s_v0, s_v1, s_err} !== 3'b000) begin err_cnt++; $display("FAIL reset_rsp_flags: got %b want 000", {s_v0, s_v1, s_err}); end
    v0 = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clock);
    reset = 1'b1;
    d0 = D_SPEC; k0 = K_SPEC; c0 = 1'b0; v0 = 1'b1;
    #1;
    cmp_cnt++; if ({s_r0, s_r1} !== 2'b10) begin err_cnt++; $display("FAIL single_grant: got r0r1=%b want 10", {s_r0, s_r1}); end
    wait_rsp(200, 2'b01);
    cmp_cnt++; if (w_ok !== 1'b1) begin err_cnt++; $display("FAIL single_rsp_timeout: got no rsp want rsp0_valid"); end
    cmp_cnt++; if (w_start1 !== 1'b1) begin err_cnt++; $display("FAIL single_start_latency: got %b want 1", w_start1); end
    cmp_cnt++; if (w_start_hi !== 2) begin err_cnt++; $display("FAIL single_start_len: got %0d want 2", w_start_hi); end
    cmp_cnt++; if ({w_cfg1, w_edata1, w_ekey1} !== {1'b0, D_SPEC, K_SPEC}) begin err_cnt++; $display("FAIL single_eng_operands: got cfg=%b data=%h key=%h", w_cfg1, w_edata1, w_ekey1); end
    cmp_cnt++; if (w_rsp - w_busy_fall !== 1) begin err_cnt++; $display("FAIL single_busy_to_valid: got %0d want 1", w_rsp - w_busy_fall); end
    cmp_cnt++; if ({s_v0, s_v1} !== 2'b10) begin err_cnt++; $display("FAIL single_rsp_chan: got v0v1=%b want 10", {s_v0, s_v1}); end
    cmp_cnt++; if (s_data !== R_SPEC) begin err_cnt++; $display("FAIL single_rsp_data: got %h want %h", s_data, R_SPEC); end
    cmp_cnt++; if (s_err !== 1'b0) begin err_cnt++; $display("FAIL single_rsp_err: got %b want 0", s_err); end
    handshake(0);
    cmp_cnt++; if ({s_v0, s_data} !== {1'b0, R_SPEC}) begin err_cnt++; $display("FAIL single_after_hs: got v0=%b data=%h", s_v0, s_data); end
  endtask

  task automatic test_simultaneous();
    @(negedge clock);
    reset = 1'b0;
    d0 = D_A; c0 = 1'b0; d1 = D_B; c1 = 1'b1; v0 = 1'b1; v1 = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    cmp_cnt++; if ({s_r0, s_r1} !== 2'b10) begin err_cnt++; $display("FAIL sim_first_grant: got r0r1=%b want 10", {s_r0, s_r1}); end
    wait_rsp(200, 2'b01);
    cmp_cnt++; if ({w_ok, s_v0, s_v1, w_any_rdy} !== 4'b1100) begin err_cnt++; $display("FAIL sim_rsp0: got ok/v0/v1/anyrdy=%b want 1100", {w_ok, s_v0, s_v1, w_any_rdy}); end
    cmp_cnt++; if (s_data !== R_A) begin err_cnt++; $display("FAIL sim_rsp0_data: got %h want %h", s_data, R_A); end
    handshake(0);
    cmp_cnt++; if ({s_v0, s_r1} !== 2'b01) begin err_cnt++; $display("FAIL sim_second_grant: got v0/r1=%b want 01", {s_v0, s_r1}); end
    wait_rsp(200, 2'b10);
    cmp_cnt++; if (w_start_hi !== 2 || w_cfg1 !== 1'b1) begin err_cnt++; $display("FAIL sim_second_start: got start=%0d cfg=%b want 2/1", w_start_hi, w_cfg1); end
    cmp_cnt++; if ({w_ok, s_v0, s_v1} !== 3'b101) begin err_cnt++; $display("FAIL sim_rsp1: got ok/v0/v1=%b want 101", {w_ok, s_v0, s_v1}); end
    cmp_cnt++; if (s_data !== R_B) begin err_cnt++; $display("FAIL sim_rsp1_data: got %h want %h", s_data, R_B); end
    handshake(1);
    d0 = D_C; v0 = 1'b1; v1 = 1'b1;
    #1;
    cmp_cnt++; if ({s_r0, s_r1} !== 2'b10) begin err_cnt++; $display("FAIL sim_third_grant: got r0r1=%b want 10", {s_r0, s_r1}); end
    wait_rsp(200, 2'b11);
    cmp_cnt++; if ({w_ok, s_v0, s_data} !== {2'b11, R_C}) begin err_cnt++; $display("FAIL sim_third_rsp: got ok=%b v0=%b data=%h", w_ok, s_v0, s_data); end
    handshake(0);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    d0 = D_A; d1 = D_B; v0 = 1'b1; v1 = 1'b1;
    #1;
    cmp_cnt++; if ({s_r0, s_r1} !== 2'b01) begin err_cnt++; $display("FAIL bp_grant: got r0r1=%b want 01", {s_r0, s_r1}); end
    wait_rsp(200, 2'b10);
    cmp_cnt++; if ({w_ok, s_v1, w_any_rdy} !== 3'b110) begin err_cnt++; $display("FAIL bp_rsp1: got ok/v1/anyrdy=%b want 110", {w_ok, s_v1, w_any_rdy}); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (s_v1 !== 1'b1 || s_data !== R_B || s_r0 !== 1'b0) bad++;
    end
    cmp_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    handshake(1);
    cmp_cnt++; if ({s_v1, s_r0} !== 2'b01) begin err_cnt++; $display("FAIL bp_regrant: got v1/r0=%b want 01", {s_v1, s_r0}); end
    wait_rsp(200, 2'b01);
    cmp_cnt++; if ({w_ok, s_v0, s_data} !== {2'b11, R_A}) begin err_cnt++; $display("FAIL bp_rsp0: got ok=%b v0=%b data=%h", w_ok, s_v0, s_data); end
    handshake(0);
  endtask

  task automatic test_same_cycle();
    m_lat[0] = 10; m_tail[0] = 0;
    d0 = D_SPEC; v0 = 1'b1;
    #1;
    wait_rsp(200, 2'b01);
    cmp_cnt++; if ({w_ok, s_v0, s_data} !== {2'b11, R_SPEC}) begin err_cnt++; $display("FAIL same_rsp: got ok=%b v0=%b data=%h", w_ok, s_v0, s_data); end
    cmp_cnt++; if (w_rsp - w_ready !== 1) begin err_cnt++; $display("FAIL same_skip_wait_idle: got %0d want 1", w_rsp - w_ready); end
    handshake(0);
    m_lat[0] = 40; m_tail[0] = 2;
  endtask

  task automatic test_timeout();
    use_t = 1'b1;
    d0 = D_B; v0 = 1'b1;
    #1;
    wait_rsp(100, 2'b01);
    cmp_cnt++; if ({w_ok, s_err, s_data} !== {2'b10, R_B}) begin err_cnt++; $display("FAIL to_pre_op: got ok=%b err=%b data=%h", w_ok, s_err, s_data); end
    handshake(0);
    m_hang[1] = 1'b1;
    d0 = D_A; v0 = 1'b1;
    #1;
    wait_rsp(100, 2'b01);
    cmp_cnt++; if ({w_ok, s_v0} !== 2'b11) begin err_cnt++; $display("FAIL to_valid: got ok/v0=%b want 11", {w_ok, s_v0}); end
    cmp_cnt++; if (w_rsp - w_wr !== 16) begin err_cnt++; $display("FAIL to_latency: got %0d want 16", w_rsp - w_wr); end
    cmp_cnt++; if ({s_err, s_data} !== {1'b1, 128'h0}) begin err_cnt++; $display("FAIL to_err_data: got err=%b data=%h want 1/0", s_err, s_data); end
    handshake(0);
    cmp_cnt++; if (s_err !== 1'b0) begin err_cnt++; $display("FAIL to_err_clear: got %b want 0", s_err); end
    m_hang[1] = 1'b0;
    d0 = D_C; v0 = 1'b1;
    #1;
    wait_rsp(100, 2'b01);
    cmp_cnt++; if ({w_ok, s_err, s_data} !== {2'b10, R_C}) begin err_cnt++; $display("FAIL to_recover: got ok=%b err=%b data=%h", w_ok, s_err, s_data); end
    handshake(0);
    use_t = 1'b0;
  endtask

  task automatic test_async_reset();
    d0 = D_A; v0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      v0 = 1'b0;
    end
    d1 = D_B; v1 = 1'b1;
    #2 reset = 1'b0;
    #1;
    cmp_cnt++; if ({s_start, s_v0, s_v1, s_err, s_r0, s_r1} !== 6'b0) begin err_cnt++; $display("FAIL areset_flags: got %b want 000000", {s_start, s_v0, s_v1, s_err, s_r0, s_r1}); end
    cmp_cnt++; if ({s_edata, s_ekey, s_data} !== '0) begin err_cnt++; $display("FAIL areset_buses: got data=%h key=%h rsp=%h", s_edata, s_ekey, s_data); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    cmp_cnt++; if ({s_r0, s_r1} !== 2'b01) begin err_cnt++; $display("FAIL areset_grant: got r0r1=%b want 01", {s_r0, s_r1}); end
    wait_rsp(200, 2'b10);
    cmp_cnt++; if ({w_ok, s_v1, s_data} !== {2'b11, R_B}) begin err_cnt++; $display("FAIL areset_rsp1: got ok=%b v1=%b data=%h", w_ok, s_v1, s_data); end
    handshake(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_same_cycle();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
